// File: rtl/cnt2note.sv
// cnt2note: measures the half period of a square wave and maps it
// to the nearest MIDI note via a one-octave base-count table.
module cnt2note #(
  parameter int BW     = 20,
  parameter int ROM_BW = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sig_i,
  output logic [7:0] note_o,
  output logic       valid_o,
  output logic       err_o,
  output logic       nosig_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {IDLE, NORM, SEARCH, DONE} state_t;

  localparam logic [BW-1:0] CMAX      = '1;
  localparam logic [3:0]    LAST      = 4'd12;
  localparam logic [3:0]    MAX_SHIFT = 4'd8;

  state_t state, state_nxt;

  logic              s1, s2, s3;
  logic              edge_det;
  logic [BW-1:0]     cnt;
  logic [BW-1:0]     n;
  logic              armed;
  logic              start;
  logic              n_big;
  logic [3:0]        shift;
  logic [3:0]        idx;
  logic [3:0]        best_idx;
  logic [3:0]        fin_idx;
  logic [ROM_BW-1:0] t_cur;
  logic [ROM_BW:0]   n_low;
  logic [ROM_BW:0]   t_ext;
  logic [ROM_BW:0]   diff;
  logic [ROM_BW:0]   best_diff;
  logic              take;
  logic [8:0]        note_sum;
  logic [7:0]        note_clamp;

  function automatic logic [ROM_BW-1:0] rom(input logic [3:0] i);
    logic [ROM_BW-1:0] t;
    case (i)
      4'd0:    t = ROM_BW'(248);
      4'd1:    t = ROM_BW'(234);
      4'd2:    t = ROM_BW'(221);
      4'd3:    t = ROM_BW'(209);
      4'd4:    t = ROM_BW'(197);
      4'd5:    t = ROM_BW'(186);
      4'd6:    t = ROM_BW'(175);
      4'd7:    t = ROM_BW'(165);
      4'd8:    t = ROM_BW'(156);
      4'd9:    t = ROM_BW'(147);
      4'd10:   t = ROM_BW'(139);
      4'd11:   t = ROM_BW'(131);
      default: t = ROM_BW'(124);
    endcase
    return t;
  endfunction

  assign edge_det = s2 ^ s3;
  assign start    = edge_det && armed && (state == IDLE);
  assign n_big    = (n >> ROM_BW) != '0;

  always_comb begin
    t_cur      = rom(idx);
    n_low      = n[ROM_BW:0];
    t_ext      = {1'b0, t_cur};
    diff       = (n_low >= t_ext) ? n_low - t_ext : t_ext - n_low;
    // strict compare keeps the lower index on a tie
    take       = (idx == 4'd0) || (diff < best_diff);
    fin_idx    = take ? idx : best_idx;
    note_sum   = 9'd21 + 9'd12 * {5'd0, MAX_SHIFT - shift}
               + {5'd0, fin_idx};
    note_clamp = (note_sum > 9'd127) ? 8'd127 : note_sum[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = NORM;
      NORM:    if (!(n_big && shift < MAX_SHIFT)) state_nxt = SEARCH;
      SEARCH:  if (idx == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (state != IDLE);
    valid_o = (state == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      cnt       <= '0;
      armed     <= 1'b0;
      nosig_o   <= 1'b0;
      n         <= '0;
      shift     <= '0;
      idx       <= '0;
      best_idx  <= '0;
      best_diff <= '0;
      note_o    <= '0;
      err_o     <= 1'b0;
    end else begin
      s1 <= sig_i;
      s2 <= s1;
      s3 <= s2;
      // every edge restarts the count, even while busy
      if (edge_det) begin
        cnt     <= BW'(1);
        armed   <= 1'b1;
        nosig_o <= 1'b0;
      end else if (cnt != CMAX) begin
        cnt <= cnt + BW'(1);
      end else begin
        armed   <= 1'b0;
        nosig_o <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            n     <= cnt;
            shift <= '0;
            idx   <= '0;
          end
        end
        NORM: begin
          if (n_big && shift < MAX_SHIFT) begin
            n     <= n >> 1;
            shift <= shift + 4'd1;
          end
        end
        SEARCH: begin
          best_idx  <= fin_idx;
          best_diff <= take ? diff : best_diff;
          idx       <= idx + 4'd1;
          if (idx == LAST) begin
            note_o <= n_big ? 8'd0 : note_clamp;
            err_o  <= n_big;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cnt2note.sv
// Directed bench for cnt2note: four instances run in parallel
// (main checks, long period, no-signal with short counter, error).
module tb_cnt2note;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a;
  logic       rst_o;
  logic       sig   [4];
  logic       valid [4];
  logic       err   [4];
  logic       nosig [4];
  logic       busy  [4];
  logic [7:0] note  [4];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vcnt   [4];
  int vcyc   [4];
  int vnote  [4];
  int verr   [4];
  int last_d [4];
  int nchk = 0;
  int nerr = 0;

  cnt2note #(.BW(20), .ROM_BW(8)) u_a (
    .clk_i(clk), .rst_i(rst_a), .sig_i(sig[0]),
    .note_o(note[0]), .valid_o(valid[0]), .err_o(err[0]),
    .nosig_o(nosig[0]), .busy_o(busy[0])
  );
  cnt2note #(.BW(20), .ROM_BW(8)) u_b (
    .clk_i(clk), .rst_i(rst_o), .sig_i(sig[1]),
    .note_o(note[1]), .valid_o(valid[1]), .err_o(err[1]),
    .nosig_o(nosig[1]), .busy_o(busy[1])
  );
  cnt2note #(.BW(10), .ROM_BW(8)) u_c (
    .clk_i(clk), .rst_i(rst_o), .sig_i(sig[2]),
    .note_o(note[2]), .valid_o(valid[2]), .err_o(err[2]),
    .nosig_o(nosig[2]), .busy_o(busy[2])
  );
  cnt2note #(.BW(20), .ROM_BW(8)) u_d (
    .clk_i(clk), .rst_i(rst_o), .sig_i(sig[3]),
    .note_o(note[3]), .valid_o(valid[3]), .err_o(err[3]),
    .nosig_o(nosig[3]), .busy_o(busy[3])
  );

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (valid[i]) begin
        vcnt[i]  <= vcnt[i] + 1;
        vcyc[i]  <= cyc;
        vnote[i] <= int'(note[i]);
        verr[i]  <= int'(err[i]);
      end
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic arm(input int u);
    @(negedge clk);
    sig[u]    = ~sig[u];
    last_d[u] = cyc;
  endtask

  // toggle p cycles after the previous toggle, expect one result
  task automatic measure(input int u, input int p, input int k,
                         input int exp_note, input int exp_err,
                         input string tag);
    int d1;
    int vc0;
    vc0 = vcnt[u];
    wait_until(last_d[u] + p);
    sig[u]    = ~sig[u];
    d1        = cyc;
    last_d[u] = d1;
    repeat (30) @(negedge clk);
    chk({tag, "_cnt"}, vcnt[u], vc0 + 1);
    chk({tag, "_cyc"}, vcyc[u], d1 + k + 17);
    chk({tag, "_note"}, vnote[u], exp_note);
    chk({tag, "_err"}, verr[u], exp_err);
  endtask

  task automatic flow_a();
    int d1;
    int vc0;
    arm(0);
    repeat (30) @(negedge clk);
    chk("a_arm_only", vcnt[0], 0);
    measure(0, 2400, 4, 78, 0, "p2400");
    measure(0, 2288, 4, 78, 0, "p2288_tie");
    measure(0, 131, 0, 127, 0, "p131_clamp");
    vc0 = vcnt[0];
    wait_until(last_d[0] + 200);
    sig[0] = ~sig[0];
    d1     = cyc;
    repeat (5) @(negedge clk);
    sig[0]    = ~sig[0];
    last_d[0] = cyc;
    repeat (30) @(negedge clk);
    chk("inj_cnt", vcnt[0], vc0 + 1);
    chk("inj_cyc", vcyc[0], d1 + 17);
    chk("inj_note", vnote[0], 121);
    measure(0, 150, 0, 126, 0, "p150_from_inj");
    vc0 = vcnt[0];
    wait_until(last_d[0] + 2400);
    sig[0] = ~sig[0];
    d1     = cyc;
    wait_until(d1 + 12);
    chk("a_busy_mid", int'(busy[0]), 1);
    rst_a = 1'b1;
    @(negedge clk);
    chk("rst_note", int'(note[0]), 0);
    chk("rst_err", int'(err[0]), 0);
    chk("rst_valid", int'(valid[0]), 0);
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_nosig", int'(nosig[0]), 0);
    rst_a = 1'b0;
    repeat (30) @(negedge clk);
    chk("rst_no_valid", vcnt[0], vc0);
    arm(0);
    repeat (30) @(negedge clk);
    chk("rearm_only", vcnt[0], vc0);
    measure(0, 2400, 4, 78, 0, "p2400_post_rst");
  endtask

  task automatic flow_c();
    arm(2);
    wait_until(last_d[2] + 1000);
    chk("c_nosig_early", int'(nosig[2]), 0);
    wait_until(last_d[2] + 1030);
    chk("c_nosig_set", int'(nosig[2]), 1);
    chk("c_nosig_no_valid", vcnt[2], 0);
    arm(2);
    repeat (30) @(negedge clk);
    chk("c_nosig_clr", int'(nosig[2]), 0);
    chk("c_rearm_only", vcnt[2], 0);
    measure(2, 150, 0, 126, 0, "c_p150");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      sig[i]    = 1'b0;
      last_d[i] = 0;
    end
    rst_a = 1'b1;
    rst_o = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_note", int'(note[0]), 0);
    chk("reset_valid", int'(valid[0]), 0);
    chk("reset_err", int'(err[0]), 0);
    chk("reset_nosig", int'(nosig[0]), 0);
    chk("reset_busy", int'(busy[0]), 0);
    rst_a = 1'b0;
    rst_o = 1'b0;
    fork
      flow_a();
      begin
        arm(1);
        measure(1, 63488, 8, 21, 0, "p63488");
      end
      flow_c();
      begin
        arm(3);
        measure(3, 70000, 8, 0, 1, "p70000_err");
      end
    join
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
